// File: rtl/pll_lock_ctrl.sv
// PLL start-up sequencer: pulses the PLL reset, waits for a synchronised lock,
// retries on timeout and holds the core in reset until lock has been stable.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       pll_fail,
    output logic [3:0] retries
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    localparam logic [2:0] S_PULSE     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lock_s;

    assign lock_s = sync2_q;

    always_comb begin
        sync1_d = locked_in;
        sync2_d = sync1_q;
    end

    // cnt restarts from zero on every state change and is parked at zero in RUN/FAIL
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = retries_q;
        case (state_q)
            S_PULSE: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retries_q == RETRY_LIMIT) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d   = S_PULSE;
                        retries_d = retries_q + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d   = S_PULSE;
                    retries_d = '0;
                end else if (soft_reset) begin
                    state_d = S_STABLE;
                end
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d   = S_PULSE;
                cnt_d     = '0;
                retries_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PULSE;
            cnt_q     <= '0;
            retries_q <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign pll_rst    = (state_q == S_PULSE);
    assign core_reset = (state_q != S_RUN);
    assign ready      = (state_q == S_RUN);
    assign pll_fail   = (state_q == S_FAIL);
    assign retries    = retries_q;

endmodule
